// File: rtl/wm_cycle_sequencer.sv
// Wash-cycle FSM: sequences fill, heat, wash, rinse passes and spin, drives Timer's phase code
// and the actuator outputs. Define WM_WATCHDOG_EN to add a per-phase watchdog that forces FAULT.
module wm_cycle_sequencer #(
    parameter int RINSE_PASSES = 2,
    parameter int WDOG_LIMIT   = 1000,
    parameter int WDOG_W       = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       cancel,
    input  logic       door_closed,
    input  logic       sig_Full,
    input  logic       sig_Temperature,
    input  logic       sig_Completed,
    output logic [2:0] state,
    output logic       water_valve,
    output logic       heater,
    output logic       motor,
    output logic       drain,
    output logic       door_lock,
    output logic       done,
    output logic       fault
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_HEAT  = 3'd2;
    localparam logic [2:0] S_WASH  = 3'd3;
    localparam logic [2:0] S_RINSE = 3'd4;
    localparam logic [2:0] S_SPIN  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_FAULT = 3'd7;

    localparam logic [2:0] RINSE_LAST = 3'(RINSE_PASSES);

    if ((RINSE_PASSES < 1) || (RINSE_PASSES > 7) || (WDOG_LIMIT < 1) ||
        (WDOG_LIMIT >= (2 ** WDOG_W))) begin : g_bad_params
        $error("wm_cycle_sequencer: parameter out of range");
    end

    logic [2:0] state_q, state_d;
    logic [2:0] rinse_q, rinse_d;
    logic [6:0] out_q, out_d;
    logic       active_s;
    logic       wdog_trip_s;

    // Actuator pattern for a phase: {valve, heater, motor, drain, lock, done, fault}
    function automatic logic [6:0] decode_outputs(input logic [2:0] st);
        logic [6:0] o;
        case (st)
            S_FILL:  o = 7'b1000100;
            S_HEAT:  o = 7'b0100100;
            S_WASH:  o = 7'b0010100;
            S_RINSE: o = 7'b0010100;
            S_SPIN:  o = 7'b0011100;
            S_DONE:  o = 7'b0000010;
            S_FAULT: o = 7'b0001001;
            default: o = 7'b0000000;
        endcase
        return o;
    endfunction

    assign active_s = (state_q >= S_FILL) && (state_q <= S_SPIN);

`ifdef WM_WATCHDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_TRIP = WDOG_W'(WDOG_LIMIT - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_LIMIT);

    logic [WDOG_W-1:0] wdog_q, wdog_d;

    // The trip fires on the edge that completes WDOG_LIMIT clocks in the phase.
    assign wdog_trip_s = active_s && (wdog_q >= WDOG_TRIP);

    // Watchdog next value: cleared on any phase change or outside the active phases.
    always_comb begin
        wdog_d = wdog_q;
        if ((state_d != state_q) || !active_s) begin
            wdog_d = '0;
        end else if (wdog_q >= WDOG_MAX) begin
            wdog_d = wdog_q;
        end else begin
            wdog_d = wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1};
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_trip_s = 1'b0;
`endif

    // Phase transitions; door-open and watchdog override cancel, which overrides Timer advances.
    always_comb begin
        state_d = state_q;
        rinse_d = (state_q == S_RINSE) ? rinse_q : 3'd0;
        if (active_s && !door_closed) begin
            state_d = S_FAULT;
            rinse_d = 3'd0;
        end else if (wdog_trip_s) begin
            state_d = S_FAULT;
            rinse_d = 3'd0;
        end else begin
            case (state_q)
                S_IDLE:  if (start && door_closed) state_d = S_FILL;  else state_d = S_IDLE;
                S_FILL:  if (cancel) state_d = S_SPIN; else if (sig_Full)        state_d = S_HEAT; else state_d = S_FILL;
                S_HEAT:  if (cancel) state_d = S_SPIN; else if (sig_Temperature) state_d = S_WASH; else state_d = S_HEAT;
                S_WASH:  if (cancel) state_d = S_SPIN; else if (sig_Completed)   state_d = S_RINSE; else state_d = S_WASH;
                S_RINSE: begin
                    if (cancel) begin
                        state_d = S_SPIN;
                        rinse_d = 3'd0;
                    end else if (sig_Completed && ((rinse_q + 3'd1) == RINSE_LAST)) begin
                        state_d = S_SPIN;
                        rinse_d = 3'd0;
                    end else if (sig_Completed) begin
                        rinse_d = rinse_q + 3'd1;
                    end else begin
                        rinse_d = rinse_q;
                    end
                end
                S_SPIN:  if (sig_Completed) state_d = S_DONE; else state_d = S_SPIN;
                S_DONE:  if (!door_closed) state_d = S_IDLE; else state_d = S_DONE;
                S_FAULT: if (cancel && door_closed) state_d = S_IDLE; else state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Actuators are registered from the next phase so they stay a pure decode of state_q.
    assign out_d = decode_outputs(state_d);

    // State, rinse count and actuator registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rinse_q <= 3'd0;
            out_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            rinse_q <= rinse_d;
            out_q   <= out_d;
        end
    end

    assign state       = state_q;
    assign water_valve = out_q[6];
    assign heater      = out_q[5];
    assign motor       = out_q[4];
    assign drain       = out_q[3];
    assign door_lock   = out_q[2];
    assign done        = out_q[1];
    assign fault       = out_q[0];

endmodule

// File: tb/tb_wm_cycle_sequencer.sv
// Directed bench for wm_cycle_sequencer: each vector drives inputs for one clock and
// checks {state, valve, heater, motor, drain, lock, done, fault} against hand-derived values.
module tb_wm_cycle_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start, cancel, door_closed, sig_Full, sig_Temperature, sig_Completed;
    logic [2:0] state;
    logic       water_valve, heater, motor, drain, door_lock, done, fault;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Expected observation per phase: {state[2:0], valve, heater, motor, drain, lock, done, fault}
    localparam logic [9:0] O_IDLE  = 10'b000_0000000;
    localparam logic [9:0] O_FILL  = 10'b001_1000100;
    localparam logic [9:0] O_HEAT  = 10'b010_0100100;
    localparam logic [9:0] O_WASH  = 10'b011_0010100;
    localparam logic [9:0] O_RINSE = 10'b100_0010100;
    localparam logic [9:0] O_SPIN  = 10'b101_0011100;
    localparam logic [9:0] O_DONE  = 10'b110_0000010;
    localparam logic [9:0] O_FAULT = 10'b111_0001001;

    // Stimulus: {start, cancel, door_closed, sig_Full, sig_Temperature, sig_Completed}
    localparam logic [5:0] I_OPEN   = 6'b000000;
    localparam logic [5:0] I_DOOR   = 6'b001000;
    localparam logic [5:0] I_START  = 6'b101000;
    localparam logic [5:0] I_FULL   = 6'b001100;
    localparam logic [5:0] I_TEMP   = 6'b001010;
    localparam logic [5:0] I_COMP   = 6'b001001;
    localparam logic [5:0] I_CANCEL = 6'b011000;
    localparam logic [5:0] I_OPEN_START  = 6'b100000;
    localparam logic [5:0] I_OPEN_TEMP   = 6'b000010;
    localparam logic [5:0] I_OPEN_CANCEL = 6'b010000;

    wm_cycle_sequencer #(
        .RINSE_PASSES(2),
        .WDOG_LIMIT  (8),
        .WDOG_W      (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .cancel         (cancel),
        .door_closed    (door_closed),
        .sig_Full       (sig_Full),
        .sig_Temperature(sig_Temperature),
        .sig_Completed  (sig_Completed),
        .state          (state),
        .water_valve    (water_valve),
        .heater         (heater),
        .motor          (motor),
        .drain          (drain),
        .door_lock      (door_lock),
        .done           (done),
        .fault          (fault)
    );

    always #5 clock = ~clock;

    function automatic logic [9:0] obs();
        return {state, water_valve, heater, motor, drain, door_lock, done, fault};
    endfunction

    task automatic set_inputs(input logic [5:0] s);
        {start, cancel, door_closed, sig_Full, sig_Temperature, sig_Completed} = s;
    endtask

    // Drive one vector for one clock; outputs are then sampled 1 ns after the edge.
    task automatic apply(input logic [5:0] s);
        set_inputs(s);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_inputs(I_OPEN);
        #12;
        total_cnt++;
        if (obs() !== O_IDLE) $display("FAIL reset_hold: got %b expected %b", obs(), O_IDLE);
        else pass_cnt++;
        apply(I_START);
        total_cnt++;
        if (obs() !== O_IDLE) $display("FAIL reset_ignores_start: got %b expected %b", obs(), O_IDLE);
        else pass_cnt++;
        set_inputs(I_DOOR);
        #2 reset = 1'b0;
        apply(I_DOOR);
        total_cnt++;
        if (obs() !== O_IDLE) $display("FAIL reset_release: got %b expected %b", obs(), O_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_nominal_cycle();
        logic [15:0] v [17];
        v = '{{I_START, O_FILL}, {I_DOOR, O_FILL}, {I_TEMP, O_FILL}, {I_FULL, O_HEAT},
              {I_COMP, O_HEAT}, {I_TEMP, O_WASH}, {I_COMP, O_RINSE}, {I_COMP, O_RINSE},
              {I_COMP, O_SPIN}, {I_COMP, O_DONE}, {I_START, O_DONE}, {I_OPEN_START, O_IDLE},
              {I_OPEN_START, O_IDLE}, {I_START, O_FILL}, {I_CANCEL, O_SPIN}, {I_COMP, O_DONE},
              {I_OPEN, O_IDLE}};
        for (int i = 0; i < 17; i++) begin
            apply(v[i][15:10]);
            total_cnt++;
            if (obs() !== v[i][9:0]) $display("FAIL nominal step %0d: got %b expected %b", i, obs(), v[i][9:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_cancel();
        logic [15:0] v [24];
        v = '{{I_START, O_FILL}, {I_FULL, O_HEAT}, {I_TEMP, O_WASH}, {I_CANCEL, O_SPIN},
              {I_CANCEL, O_SPIN}, {I_COMP, O_DONE}, {I_CANCEL, O_DONE}, {I_OPEN, O_IDLE},
              {I_START, O_FILL}, {I_FULL, O_HEAT}, {I_TEMP, O_WASH}, {I_COMP, O_RINSE},
              {I_COMP, O_RINSE}, {I_CANCEL, O_SPIN}, {I_COMP, O_DONE}, {I_OPEN, O_IDLE},
              {I_START, O_FILL}, {I_FULL, O_HEAT}, {I_TEMP, O_WASH}, {I_COMP, O_RINSE},
              {I_COMP, O_RINSE}, {I_COMP, O_SPIN}, {I_COMP, O_DONE}, {I_OPEN, O_IDLE}};
        for (int i = 0; i < 24; i++) begin
            apply(v[i][15:10]);
            total_cnt++;
            if (obs() !== v[i][9:0]) $display("FAIL cancel step %0d: got %b expected %b", i, obs(), v[i][9:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_door_fault();
        logic [15:0] v [15];
        v = '{{I_START, O_FILL}, {I_OPEN_CANCEL, O_FAULT}, {I_CANCEL, O_IDLE}, {I_START, O_FILL},
              {I_FULL, O_HEAT}, {I_OPEN_TEMP, O_FAULT}, {I_OPEN, O_FAULT}, {I_DOOR, O_FAULT},
              {I_OPEN_CANCEL, O_FAULT}, {I_COMP, O_FAULT}, {I_CANCEL, O_IDLE}, {I_START, O_FILL},
              {I_CANCEL, O_SPIN}, {I_OPEN, O_FAULT}, {I_CANCEL, O_IDLE}};
        for (int i = 0; i < 15; i++) begin
            apply(v[i][15:10]);
            total_cnt++;
            if (obs() !== v[i][9:0]) $display("FAIL door_fault step %0d: got %b expected %b", i, obs(), v[i][9:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_idle_ignores();
        logic [5:0] v [5];
        v = '{I_OPEN_START, I_FULL, I_CANCEL, I_COMP, I_OPEN_TEMP};
        for (int i = 0; i < 5; i++) begin
            apply(v[i]);
            total_cnt++;
            if (obs() !== O_IDLE) $display("FAIL idle_ignore step %0d: got %b expected %b", i, obs(), O_IDLE);
            else pass_cnt++;
        end
    endtask

`ifdef WM_WATCHDOG_EN
    task automatic test_watchdog();
        apply(I_START);
        for (int i = 0; i < 7; i++) begin
            apply(I_DOOR);
            total_cnt++;
            if (obs() !== O_FILL) $display("FAIL wdog_fill clk %0d: got %b expected %b", i + 1, obs(), O_FILL);
            else pass_cnt++;
        end
        apply(I_DOOR);
        total_cnt++;
        if (obs() !== O_FAULT) $display("FAIL wdog_trip_fill: got %b expected %b", obs(), O_FAULT);
        else pass_cnt++;
        apply(I_CANCEL);
        apply(I_START);
        for (int i = 0; i < 5; i++) apply(I_DOOR);
        apply(I_FULL);
        for (int i = 0; i < 7; i++) begin
            apply(I_DOOR);
            total_cnt++;
            if (obs() !== O_HEAT) $display("FAIL wdog_heat clk %0d: got %b expected %b", i + 1, obs(), O_HEAT);
            else pass_cnt++;
        end
        apply(I_DOOR);
        total_cnt++;
        if (obs() !== O_FAULT) $display("FAIL wdog_trip_heat: got %b expected %b", obs(), O_FAULT);
        else pass_cnt++;
        apply(I_CANCEL);
        total_cnt++;
        if (obs() !== O_IDLE) $display("FAIL wdog_recover: got %b expected %b", obs(), O_IDLE);
        else pass_cnt++;
    endtask
`endif

    task automatic test_async_reset();
        logic [15:0] v [7];
        apply(I_START);
        apply(I_FULL);
        apply(I_TEMP);
        apply(I_COMP);
        apply(I_COMP);
        total_cnt++;
        if (obs() !== O_RINSE) $display("FAIL areset_setup: got %b expected %b", obs(), O_RINSE);
        else pass_cnt++;
        set_inputs(I_DOOR);
        #3 reset = 1'b1;
        #1;
        total_cnt++;
        if (obs() !== O_IDLE) $display("FAIL areset_immediate: got %b expected %b", obs(), O_IDLE);
        else pass_cnt++;
        #2 reset = 1'b0;
        v = '{{I_START, O_FILL}, {I_FULL, O_HEAT}, {I_TEMP, O_WASH}, {I_COMP, O_RINSE},
              {I_COMP, O_RINSE}, {I_COMP, O_SPIN}, {I_COMP, O_DONE}};
        for (int i = 0; i < 7; i++) begin
            apply(v[i][15:10]);
            total_cnt++;
            if (obs() !== v[i][9:0]) $display("FAIL areset_rerun step %0d: got %b expected %b", i, obs(), v[i][9:0]);
            else pass_cnt++;
        end
        apply(I_OPEN);
    endtask

    initial begin
        test_reset();
        test_nominal_cycle();
        test_cancel();
        test_door_fault();
        test_idle_ignores();
`ifdef WM_WATCHDOG_EN
        test_watchdog();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
